// File: rtl/zbus_iocycle.sv
// Z80 I/O cycle tracker for the ZX-bus IORQ/IORQGE manager.
// Synchronises the Z80 strobes, latches the port address and qualifies internal port hits.
// Holds the Z80 in WAIT while an external device waits, with a timeout on that wait.
module zbus_iocycle #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        z_iorq_n,
  input  logic        z_m1_n,
  input  logic        z_rd_n,
  input  logic        z_wr_n,
  input  logic [15:0] z_a,
  input  logic        porthit_in,
  input  logic        ext_io_en,
  input  logic        ext_wait_n,
  input  logic        to_clr,
  output logic [15:0] a_lat,
  output logic        iorq,
  output logic        iorq_n,
  output logic        rd,
  output logic        wr,
  output logic        porthit,
  output logic        iorq_s,
  output logic        iorq_e,
  output logic        wait_n,
  output logic        timeout
);

  localparam logic [7:0] ToLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StDecode, StExtWait, StHold} state_e;

  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       set_to;

  logic [SYNC_STAGES-1:0] iorq_n_sync, m1_n_sync, rd_n_sync, wr_n_sync, ext_wait_n_sync;
  logic iorq_n_s, m1_n_s, rd_n_s, wr_n_s, ext_wait_n_s;
  logic req;

  // Input synchronisers; idle level of every strobe is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iorq_n_sync     <= '1;
      m1_n_sync       <= '1;
      rd_n_sync       <= '1;
      wr_n_sync       <= '1;
      ext_wait_n_sync <= '1;
    end else begin
      iorq_n_sync     <= {iorq_n_sync[SYNC_STAGES-2:0], z_iorq_n};
      m1_n_sync       <= {m1_n_sync[SYNC_STAGES-2:0], z_m1_n};
      rd_n_sync       <= {rd_n_sync[SYNC_STAGES-2:0], z_rd_n};
      wr_n_sync       <= {wr_n_sync[SYNC_STAGES-2:0], z_wr_n};
      ext_wait_n_sync <= {ext_wait_n_sync[SYNC_STAGES-2:0], ext_wait_n};
    end
  end

  assign iorq_n_s     = iorq_n_sync[SYNC_STAGES-1];
  assign m1_n_s       = m1_n_sync[SYNC_STAGES-1];
  assign rd_n_s       = rd_n_sync[SYNC_STAGES-1];
  assign wr_n_s       = wr_n_sync[SYNC_STAGES-1];
  assign ext_wait_n_s = ext_wait_n_sync[SYNC_STAGES-1];

  // Interrupt acknowledge (IORQ together with M1) is not an I/O cycle.
  assign req = !iorq_n_s && m1_n_s;

  // Next-state and wait-counter logic; a dropped req aborts from any active state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    set_to  = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) state_d = StDecode;
      end
      StDecode: begin
        if (!req) begin
          state_d = StIdle;
        end else if (porthit_in || !ext_io_en) begin
          state_d = StHold;
        end else begin
          cnt_d   = 8'd0;
          state_d = StExtWait;
        end
      end
      StExtWait: begin
        if (!req) begin
          state_d = StIdle;
        end else if (ext_wait_n_s) begin
          state_d = StHold;
        end else if (cnt_q >= ToLast) begin
          set_to  = 1'b1;
          state_d = StHold;
        end else if (cnt_q != 8'hff) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHold: begin
        if (!req) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counter, address latch and registered output decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      a_lat   <= 16'd0;
      iorq    <= 1'b0;
      iorq_n  <= 1'b1;
      rd      <= 1'b0;
      wr      <= 1'b0;
      porthit <= 1'b0;
      iorq_s  <= 1'b0;
      iorq_e  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && req) a_lat <= z_a;
      iorq    <= (state_d != StIdle);
      iorq_n  <= (state_d == StIdle);
      rd      <= (state_d != StIdle) && !rd_n_s;
      wr      <= (state_d != StIdle) && !wr_n_s;
      iorq_s  <= (state_q == StIdle) && (state_d == StDecode);
      iorq_e  <= (state_q != StIdle) && (state_d == StIdle);
      if (state_d == StIdle) begin
        porthit <= 1'b0;
      end else if (state_q == StDecode) begin
        porthit <= porthit_in;
      end
      // A new expiry beats a simultaneous clear.
      timeout <= set_to | (timeout & ~to_clr);
    end
  end

  // WAIT follows the device only while in EXTWAIT, so it releases with the state change.
  always_comb begin
    wait_n = 1'b1;
    if (state_q == StExtWait) wait_n = ext_wait_n_s;
  end

endmodule

// File: doc/zbus_iocycle.md
Name: zbus_iocycle

Overview:
- Upstream stage of the ZX-bus IORQ/IORQGE manager.
- Synchronises raw Z80 I/O control strobes into the system clock domain and tracks each I/O cycle with an FSM.
- Latches the port address and qualifies internal port hits.
- Stretches the cycle with Z80 WAIT while an external ZX-bus device holds its own WAIT, with a timeout.
- Outputs (iorq, iorq_n, rd, porthit) feed the IORQ/IORQGE/free-bus stage directly.

Parameters:
- SYNC_STAGES, 2: flop depth of input synchronisers (min 2).
- TIMEOUT, 200: max clk cycles of external wait before forced release (1..255).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- z_iorq_n  in  1  raw Z80 IORQ_n.
- z_m1_n  in  1  raw Z80 M1_n.
- z_rd_n  in  1  raw Z80 RD_n.
- z_wr_n  in  1  raw Z80 WR_n.
- z_a  in  16  Z80 address bus.
- porthit_in  in  1  combinational internal-port decode of a_lat.
- ext_io_en  in  1  external ZX-bus I/O enabled.
- ext_wait_n  in  1  raw WAIT_n from ZX-bus device.
- to_clr  in  1  clears timeout flag.
- a_lat  out  16  port address latched at cycle start.
- iorq  out  1  qualified I/O cycle active (M1 excluded).
- iorq_n  out  1  inverse of iorq.
- rd  out  1  read I/O cycle active.
- wr  out  1  write I/O cycle active.
- porthit  out  1  cycle targets an internal port.
- iorq_s  out  1  one-clk pulse at cycle start.
- iorq_e  out  1  one-clk pulse at cycle end.
- wait_n  out  1  Z80 WAIT_n request.
- timeout  out  1  sticky: external wait expired.

Behaviour:
- Synchronisers:
  - z_iorq_n, z_m1_n, z_rd_n, z_wr_n and ext_wait_n each pass through SYNC_STAGES flops; reset value 1.
  - Suffix _s denotes the last stage.
  - req = !iorq_n_s && m1_n_s; interrupt acknowledge (IORQ with M1) never starts a cycle.
- FSM states: IDLE, DECODE, EXTWAIT, HOLD.
  - Reset state is IDLE.
- Reset values: a_lat=0, iorq=0, iorq_n=1, rd=0, wr=0, porthit=0, iorq_s=0, iorq_e=0, wait_n=1, timeout=0, wait counter=0.
- IDLE:
  - When req=1: a_lat<=z_a, iorq_s=1 for the next cycle, go to DECODE.
  - Latency is SYNC_STAGES+1 clk from the z_iorq_n falling edge to iorq=1.
- DECODE (exactly 1 clk):
  - porthit<=porthit_in.
  - If porthit_in=1 or ext_io_en=0, go to HOLD.
  - Otherwise clear the counter and go to EXTWAIT.
- EXTWAIT:
  - wait_n = ext_wait_n_s.
  - Counter increments each clk while ext_wait_n_s=0.
  - ext_wait_n_s=1 → HOLD.
  - Counter reaches TIMEOUT-1 with ext_wait_n_s still 0 → timeout<=1, HOLD; wait_n returns to 1 in the same clk as the state change.
- HOLD:
  - wait_n=1.
  - Stay while req=1.
  - On req=0: IDLE, iorq_e=1 for one clk, porthit<=0.
- Abort:
  - req=0 in DECODE or EXTWAIT → IDLE, iorq_e pulse, wait_n=1 immediately, porthit<=0.
- Output decode (registered):
  - iorq=1 in every state except IDLE; iorq_n=!iorq.
  - rd = iorq && !rd_n_s; wr = iorq && !wr_n_s.
- Address: a_lat holds its value through the cycle and after it; it updates only on IDLE→DECODE.
- Back-to-back cycles: at least one IDLE clk between iorq_e and the next iorq_s. A req re-asserting in the same clk as the drop is seen on the next IDLE clk.
- timeout flag:
  - Cleared by to_clr.
  - If set and clear occur in the same clk, set wins.
- Counter width is 8 bits; it saturates and never wraps.
- Reset mid-cycle: all outputs return immediately (asynchronously) to reset values; wait_n=1.

Test Plan:
- OUT to 0x00FE, porthit_in=1, SYNC_STAGES=2:
  - iorq=1 three clk after z_iorq_n falls; iorq_s single pulse; a_lat=0x00FE.
  - wr=1, rd=0, porthit=1, wait_n stays 1.
  - iorq_e pulse after release; porthit returns to 0.
- IORQ with M1=0 (INTA) → iorq stays 0, no iorq_s/iorq_e, no wait.
- IN from 0x1234, porthit_in=0, ext_io_en=1, ext_wait_n low for 10 clk:
  - wait_n=0 for those clk (after sync latency) then 1; rd=1; timeout stays 0.
- Same as previous but ext_wait_n held low, TIMEOUT=200:
  - wait_n released exactly 200 clk after entering EXTWAIT; timeout=1 sticky.
  - to_clr clears it; to_clr and a new expiry in the same clk leave timeout=1.
- z_iorq_n released mid-EXTWAIT → wait_n=1 and iorq_e in the same clk, IDLE.
- rst_n pulsed low mid-HOLD → all outputs at reset values asynchronously; next OUT cycle proceeds normally.
